// File: rtl/pipe_shifter.sv
// pipe_shifter: pipelined barrel shifter with valid/ready handshakes.
//
// The shift is built from log2(WIDTH) mux layers (layer k shifts by 2^k when
// amt[k] is set). The layers are split into PIPE_STAGES register groups of
// ceil(log2(WIDTH)/PIPE_STAGES) layers; the last group takes the remainder
// and may be empty, but it still contributes one register stage.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/ready    input handshake; in_ready = !out_valid || out_ready
//   in_data           operand
//   in_amt            shift amount (SHAMT_W bits, unsigned)
//   in_op             00 SLL, 01 SRL, 10 SRA, 11 ROL
//   in_tag            sideband, returned unmodified with the result
//   out_valid/ready   output handshake
//   out_data, out_tag result and its tag
//   out_zero          high when a valid result is all zeros
module pipe_shifter #(
  parameter int WIDTH = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W = 4,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_amt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_zero
);

  localparam int LAYERS_PER_STAGE = (SHAMT_W + PIPE_STAGES - 1) / PIPE_STAGES;
  localparam int LAST = PIPE_STAGES - 1;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  logic [PIPE_STAGES-1:0] valid_r;
  logic [WIDTH-1:0]       data_r [PIPE_STAGES];
  logic [1:0]             op_r   [PIPE_STAGES];
  logic [SHAMT_W-1:0]     amt_r  [PIPE_STAGES];
  logic [TAG_W-1:0]       tag_r  [PIPE_STAGES];

  logic [WIDTH-1:0]       nxt_data_s [PIPE_STAGES];
  logic                   advance_s;

  // One mux layer: shift d by s positions according to op.
  // The SRA fill is the current MSB, which stays equal to the original
  // sign bit through every preceding arithmetic layer.
  function automatic logic [WIDTH-1:0] shift_layer(input logic [WIDTH-1:0] d,
                                                   input logic [1:0]       op,
                                                   input int               s);
    logic [WIDTH-1:0] r;
    case (op)
      OP_SLL:  r = d << s;
      OP_SRL:  r = d >> s;
      OP_SRA:  r = $unsigned($signed(d) >>> s);
      OP_ROL:  r = (d << s) | (d >> (WIDTH - s));
      default: r = d;
    endcase
    return r;
  endfunction

  // Apply the layers owned by register group grp.
  function automatic logic [WIDTH-1:0] group_shift(input logic [WIDTH-1:0]   d,
                                                   input logic [1:0]         op,
                                                   input logic [SHAMT_W-1:0] amt,
                                                   input int                 grp);
    logic [WIDTH-1:0] r;
    r = d;
    for (int k = 0; k < SHAMT_W; k++) begin
      if ((k >= grp * LAYERS_PER_STAGE) && (k < (grp + 1) * LAYERS_PER_STAGE) && amt[k]) begin
        r = shift_layer(r, op, 32'sd1 << k);
      end
    end
    return r;
  endfunction

  // The whole pipeline moves together whenever the output slot frees up.
  assign advance_s = ~valid_r[LAST] | out_ready;

  // Combinational layer groups feeding each stage register.
  always_comb begin
    nxt_data_s[0] = group_shift(in_data, in_op, in_amt, 32'sd0);
    for (int g = 1; g < PIPE_STAGES; g++) begin
      nxt_data_s[g] = group_shift(data_r[g-1], op_r[g-1], amt_r[g-1], g);
    end
  end

  // Stage registers: clear on reset, advance as a unit, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int g = 0; g < PIPE_STAGES; g++) begin
        valid_r[g] <= 1'b0;
        data_r[g]  <= {WIDTH{1'b0}};
        op_r[g]    <= 2'b00;
        amt_r[g]   <= {SHAMT_W{1'b0}};
        tag_r[g]   <= {TAG_W{1'b0}};
      end
    end else if (advance_s) begin
      valid_r[0] <= in_valid;
      data_r[0]  <= nxt_data_s[0];
      op_r[0]    <= in_op;
      amt_r[0]   <= in_amt;
      tag_r[0]   <= in_tag;
      for (int g = 1; g < PIPE_STAGES; g++) begin
        valid_r[g] <= valid_r[g-1];
        data_r[g]  <= nxt_data_s[g];
        op_r[g]    <= op_r[g-1];
        amt_r[g]   <= amt_r[g-1];
        tag_r[g]   <= tag_r[g-1];
      end
    end
  end

  assign in_ready  = advance_s;
  assign out_valid = valid_r[LAST];
  assign out_data  = data_r[LAST];
  assign out_tag   = tag_r[LAST];
  // Taken from the final register only; qualified by valid so the
  // cleared (all-zero) reset contents read as out_zero = 0.
  assign out_zero  = valid_r[LAST] & ~(|data_r[LAST]);

endmodule
